// File: rtl/orao_autotype_seq_if.sv
// orao_autotype_seq_if: start/button inputs and core-facing outputs of the autotype sequencer
interface orao_autotype_seq_if;
  logic       start;
  logic       btn_n_reset;
  logic       btn_b;
  logic       btn_c;
  logic       btn_enter;
  logic       cpu_n_reset;
  logic       key_b;
  logic       key_c;
  logic       key_enter;
  logic       busy;
  logic [2:0] step;
  modport master (
    output start, btn_n_reset, btn_b, btn_c, btn_enter,
    input  cpu_n_reset, key_b, key_c, key_enter, busy, step
  );
  modport slave (
    input  start, btn_n_reset, btn_b, btn_c, btn_enter,
    output cpu_n_reset, key_b, key_c, key_enter, busy, step
  );
endinterface

// File: rtl/orao_autotype_seq.sv
// orao_autotype_seq: scripted reset/keystroke sequencer for the Orao core, merged with manual buttons
module orao_autotype_seq #(
  parameter int TICK_DIV    = 25000,
  parameter int RESET_TICKS = 200,
  parameter int PRESS_TICKS = 100,
  parameter int GAP_TICKS   = 400,
  parameter bit AUTOSTART   = 1'b1
) (
  input logic                clk,
  input logic                n_reset,
  orao_autotype_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP, DONE} state_t;
  localparam logic [2:0] OP_END       = 3'd0;
  localparam logic [2:0] OP_RESET     = 3'd1;
  localparam logic [2:0] OP_KEY_B     = 3'd2;
  localparam logic [2:0] OP_KEY_C     = 3'd3;
  localparam logic [2:0] OP_KEY_ENTER = 3'd4;
  localparam logic [2:0] OP_WAIT      = 3'd5;
  localparam logic [2:0] SCRIPT [8] = '{OP_RESET, OP_KEY_B, OP_KEY_C, OP_KEY_ENTER,
                                        OP_KEY_ENTER, OP_WAIT, OP_KEY_ENTER, OP_END};
  localparam logic [31:0] DIV     = 32'(TICK_DIV);
  localparam logic [31:0] RESET_T = 32'(RESET_TICKS > 0 ? RESET_TICKS : 1);
  localparam logic [31:0] PRESS_T = 32'(PRESS_TICKS > 0 ? PRESS_TICKS : 1);
  localparam logic [31:0] GAP_T   = 32'(GAP_TICKS > 0 ? GAP_TICKS : 1);
  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [31:0] pre_q, pre_d, tick_q, tick_d;
  logic        cpu_n_reset_q, cpu_n_reset_d;
  logic        key_b_q, key_b_d, key_c_q, key_c_d, key_enter_q, key_enter_d;
  logic        busy_q, busy_d;
  logic [2:0]  op, next_op, act_op;
  logic [31:0] dur;
  logic        running, wrap, last, abort, run, script;
  // Undefined opcodes terminate the script just like END.
  function automatic logic is_end(input logic [2:0] o);
    return o == OP_END || o > OP_WAIT;
  endfunction
  // Next-state, step, timing and merged outputs, all derived from the next state.
  always_comb begin
    op            = SCRIPT[step_q];
    next_op       = SCRIPT[step_q + 3'd1];
    running       = state_q == ACTIVE || state_q == GAP;
    dur           = state_q == GAP ? GAP_T : op == OP_RESET ? RESET_T : PRESS_T;
    wrap          = pre_q == DIV - 32'd1;
    last          = wrap && tick_q == dur - 32'd1;
    abort         = running && (bus.btn_b || bus.btn_c || bus.btn_enter || !bus.btn_n_reset);
    run           = (state_q == IDLE && (AUTOSTART || bus.start)) || (state_q == DONE && bus.start);
    state_d       = abort ? DONE :
                    run ? ACTIVE :
                    state_q == ACTIVE && last ? GAP :
                    state_q == GAP && last ? (is_end(next_op) ? DONE : ACTIVE) :
                    state_q;
    step_d        = run ? 3'd0 : !abort && state_q == GAP && last ? step_q + 3'd1 : step_q;
    pre_d         = state_d != state_q || !running || wrap ? 32'd0 : pre_q + 32'd1;
    tick_d        = state_d != state_q || !running ? 32'd0 : wrap ? tick_q + 32'd1 : tick_q;
    act_op        = SCRIPT[step_d];
    script        = state_d == ACTIVE;
    cpu_n_reset_d = bus.btn_n_reset && !(script && act_op == OP_RESET);
    key_b_d       = bus.btn_b || (script && act_op == OP_KEY_B);
    key_c_d       = bus.btn_c || (script && act_op == OP_KEY_C);
    key_enter_d   = bus.btn_enter || (script && act_op == OP_KEY_ENTER);
    busy_d        = state_d == ACTIVE || state_d == GAP;
  end
  // State, counters and registered outputs; reset holds the core in reset.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= IDLE;
      step_q        <= 3'd0;
      pre_q         <= 32'd0;
      tick_q        <= 32'd0;
      cpu_n_reset_q <= 1'b0;
      key_b_q       <= 1'b0;
      key_c_q       <= 1'b0;
      key_enter_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      pre_q         <= pre_d;
      tick_q        <= tick_d;
      cpu_n_reset_q <= cpu_n_reset_d;
      key_b_q       <= key_b_d;
      key_c_q       <= key_c_d;
      key_enter_q   <= key_enter_d;
      busy_q        <= busy_d;
    end
  end
  assign bus.cpu_n_reset = cpu_n_reset_q;
  assign bus.key_b       = key_b_q;
  assign bus.key_c       = key_c_q;
  assign bus.key_enter   = key_enter_q;
  assign bus.busy        = busy_q;
  assign bus.step        = step_q;
endmodule
